// File: rtl/perm_engine.sv
// Programmable bit-permutation engine: out[i] = in[tbl[i]], applied 0..MAX_ROUNDS times per beat.
// Optional inverse pass (in_inv port) is enabled by defining PERM_ENGINE_INVERSE_EN.
module perm_engine #(
    parameter  int WIDTH      = 32,
    parameter  int MAX_ROUNDS = 16,
    localparam int IDXW       = $clog2(WIDTH),
    localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [IDXW-1:0]  cfg_src,
    output logic             cfg_err,
    input  logic             cfg_err_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [RW-1:0]    in_rounds,
`ifdef PERM_ENGINE_INVERSE_EN
    input  logic             in_inv,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [IDXW-1:0]   tbl [WIDTH];
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  fwd_next;
    logic [WIDTH-1:0]  next_work;
    logic [RW-1:0]     count;
    logic [RW-1:0]     rounds_sat;
    logic              cfg_bad;
`ifdef PERM_ENGINE_INVERSE_EN
    logic              inv;
    logic [WIDTH-1:0]  inv_next;
`endif

    always_comb begin
        fwd_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fwd_next[i] = work[tbl[i]];
        end
    end

`ifdef PERM_ENGINE_INVERSE_EN
    // Inverse scatters each bit to its table target; collisions OR together.
    always_comb begin
        inv_next = '0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tbl[i] == IDXW'(k)) begin
                    inv_next[k] = inv_next[k] | work[i];
                end
            end
        end
    end

    assign next_work = inv ? inv_next : fwd_next;
`else
    assign next_work = fwd_next;
`endif

    assign rounds_sat = (32'(in_rounds) > MAX_ROUNDS) ? RW'(MAX_ROUNDS) : in_rounds;
    assign cfg_bad    = (state != IDLE) || (32'(cfg_idx) >= WIDTH) || (32'(cfg_src) >= WIDTH);
    assign out_data   = work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                tbl[i] <= IDXW'(i);
            end
        end else if (cfg_we && !cfg_bad) begin
            tbl[cfg_idx] <= cfg_src;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if (cfg_we && cfg_bad) begin
            cfg_err <= 1'b1;
        end else if (cfg_err_clr) begin
            cfg_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef PERM_ENGINE_INVERSE_EN
            inv       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        count    <= rounds_sat;
                        in_ready <= 1'b0;
`ifdef PERM_ENGINE_INVERSE_EN
                        inv      <= in_inv;
`endif
                        state    <= (rounds_sat == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    work  <= next_work;
                    count <= count - RW'(1);
                    if (count == RW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE, then waits for out_ready.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perm_engine.sv
// Directed self-checking bench for perm_engine: passthrough, DES P, rotate, saturation, errors, reset.
module tb_perm_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [4:0]  cfg_src = '0;
    logic        cfg_err;
    logic        cfg_err_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_rounds = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef PERM_ENGINE_INVERSE_EN
    logic        in_inv = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int lat;
    logic [31:0] held;
    int des_p [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                       1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};

    perm_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_src     (cfg_src),
        .cfg_err     (cfg_err),
        .cfg_err_clr (cfg_err_clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_rounds   (in_rounds),
`ifdef PERM_ENGINE_INVERSE_EN
        .in_inv      (in_inv),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task step();
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task writeEntry(input logic [4:0] idx, input logic [4:0] src);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_src = src;
        step();
        cfg_we  = 1'b0;
    endtask

    task applyStimulus(input logic [31:0] data, input logic [4:0] rounds);
        in_valid  = 1'b1;
        in_data   = data;
        in_rounds = rounds;
        step();
        in_valid  = 1'b0;
    endtask

    task waitOutput(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_out_data", out_data, 32'h0);
        checkOutput("reset_cfg_err", 32'(cfg_err), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

        applyStimulus(32'hDEADBEEF, 5'd0);
        checkOutput("passthru_not_early", 32'(out_valid), 32'h0);
        waitOutput(lat);
        checkOutput("passthru_latency", 32'(lat), 32'd1);
        checkOutput("passthru_data", out_data, 32'hDEADBEEF);
        checkOutput("passthru_cfg_err", 32'(cfg_err), 32'h0);
        consume();
        checkOutput("passthru_valid_drop", 32'(out_valid), 32'h0);

        for (int i = 0; i < 32; i++) writeEntry(5'(i), 5'(des_p[i]));
        applyStimulus(32'h0000_8000, 5'd1);
        waitOutput(lat);
        checkOutput("des_r1_latency", 32'(lat), 32'd2);
        checkOutput("des_r1_data", out_data, 32'h0000_0001);
        consume();
        applyStimulus(32'h0000_8000, 5'd2);
        waitOutput(lat);
        checkOutput("des_r2_data", out_data, 32'h0000_0100);
        consume();
        applyStimulus(32'h8000_0000, 5'd1);
        waitOutput(lat);
        checkOutput("des_bit31_data", out_data, 32'h0010_0000);
        consume();
`ifdef PERM_ENGINE_INVERSE_EN
        in_inv = 1'b1;
        applyStimulus(32'h0000_0001, 5'd1);
        in_inv = 1'b0;
        waitOutput(lat);
        checkOutput("des_inverse_data", out_data, 32'h0000_8000);
        consume();
`endif

        for (int i = 0; i < 32; i++) writeEntry(5'(i), 5'((i + 31) % 32));
        applyStimulus(32'h0000_0001, 5'd3);
        waitOutput(lat);
        checkOutput("rot_latency", 32'(lat), 32'd4);
        checkOutput("rot_data", out_data, 32'h0000_0008);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("hold_data", out_data, held);
            checkOutput("hold_in_ready", 32'(in_ready), 32'h0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'h1);
        end
        consume();
        checkOutput("rot_valid_drop", 32'(out_valid), 32'h0);
        checkOutput("rot_in_ready_back", 32'(in_ready), 32'h1);

        applyStimulus(32'h0000_0001, 5'd31);
        waitOutput(lat);
        checkOutput("sat_latency", 32'(lat), 32'd17);
        checkOutput("sat_data", out_data, 32'h0001_0000);
        consume();

        applyStimulus(32'h0000_0001, 5'd3);
        cfg_we = 1'b1; cfg_idx = 5'd0; cfg_src = 5'd5;
        step();
        cfg_we = 1'b0;
        checkOutput("run_write_err", 32'(cfg_err), 32'h1);
        cfg_we = 1'b1; cfg_err_clr = 1'b1;
        step();
        cfg_we = 1'b0; cfg_err_clr = 1'b0;
        checkOutput("err_set_wins", 32'(cfg_err), 32'h1);
        waitOutput(lat);
        checkOutput("run_write_data", out_data, 32'h0000_0008);
        consume();
        applyStimulus(32'h0000_0020, 5'd1);
        waitOutput(lat);
        checkOutput("table_unchanged", out_data, 32'h0000_0040);
        consume();
        cfg_err_clr = 1'b1;
        step();
        cfg_err_clr = 1'b0;
        checkOutput("err_cleared", 32'(cfg_err), 32'h0);

        applyStimulus(32'hA5A5_A5A5, 5'd0);
        waitOutput(lat);
        checkOutput("done_valid_before_reset", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("done_reset_valid", 32'(out_valid), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        applyStimulus(32'hFFFF_0000, 5'd10);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("run_reset_valid", 32'(out_valid), 32'h0);
        checkOutput("run_reset_data", out_data, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("run_reset_in_ready", 32'(in_ready), 32'h1);
        applyStimulus(32'h1234_5678, 5'd2);
        waitOutput(lat);
        checkOutput("identity_after_reset", out_data, 32'h1234_5678);
        consume();

        cfg_we = 1'b1; cfg_idx = 5'd0; cfg_src = 5'd1;
        in_valid = 1'b1; in_data = 32'h0000_0002; in_rounds = 5'd1;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        waitOutput(lat);
        checkOutput("write_with_accept", out_data, 32'h0000_0003);
        checkOutput("write_with_accept_err", 32'(cfg_err), 32'h0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
